// File: rtl/ifetch_prefetch_buffer.sv
// Instruction-fetch prefetch buffer: streams sequential words from a one-outstanding memory
// into a small {pc, instr} FIFO for decode; a redirect flushes the FIFO and refetches.
module ifetch_prefetch_buffer #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_rvalid,
    input  logic [31:0]            mem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [31:0]            instr,
    output logic [ADDR_W-1:0]      instr_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetchState_e;

    fetchState_e       state;
    fetchState_e       nextState;

    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] redirectPc;
    logic [ADDR_W-1:0] addrNext;
    logic              addrLoad;

    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [31:0]       instrMem [DEPTH];
    logic [ADDR_W-1:0] pcMem    [DEPTH];

    logic              popEn;
    logic              pushEn;
    logic [CNT_W-1:0]  cntAfterPop;
    logic [CNT_W-1:0]  nextCnt;
    logic              hasRoom;

    // Targets are word aligned; the low two bits are simply masked off.
    assign redirectPc  = redirect_pc & ~ADDR_W'(3);

    assign instr_valid = (count != '0);
    assign popEn       = instr_valid & instr_ready & ~redirect;
    assign pushEn      = (state == WAIT) & mem_rvalid & ~redirect;
    assign cntAfterPop = count - CNT_W'(popEn);
    assign nextCnt     = cntAfterPop + CNT_W'(pushEn);
    assign hasRoom     = (cntAfterPop < FULL_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (!redirect && hasRoom) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    nextState = mem_rvalid ? IDLE : DISCARD;
                end else if (mem_rvalid) begin
                    nextState = (nextCnt < FULL_CNT) ? WAIT : IDLE;
                end
            end
            DISCARD: begin
                if (mem_rvalid) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // A new address is loaded only when a request starts: from IDLE, or back-to-back after a push.
    always_comb begin
        mem_req  = (state != IDLE);
        addrLoad = 1'b0;
        addrNext = fetchPc;
        if (nextState == WAIT) begin
            if (state == IDLE) begin
                addrLoad = 1'b1;
                addrNext = fetchPc;
            end else if (pushEn) begin
                addrLoad = 1'b1;
                addrNext = fetchPc + ADDR_W'(4);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc  <= RESET_PC;
            mem_addr <= RESET_PC;
        end else begin
            if (redirect) begin
                fetchPc <= redirectPc;
            end else if (pushEn) begin
                fetchPc <= fetchPc + ADDR_W'(4);
            end
            if (addrLoad) begin
                mem_addr <= addrNext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (redirect) begin
            count <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            count <= nextCnt;
            if (pushEn) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (popEn) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
        end
    end

    // Entry storage carries no reset; only count decides what is visible.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            instrMem[wrPtr] <= mem_rdata;
            pcMem[wrPtr]    <= fetchPc;
        end
    end

    assign instr    = instr_valid ? instrMem[rdPtr] : '0;
    assign instr_pc = instr_valid ? pcMem[rdPtr]    : '0;

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Bench for ifetch_prefetch_buffer: variable-latency memory responder, expected-stream scoreboard
// with an independent pop monitor, directed scenarios and a randomized redirect/stall phase.
module tb_ifetch_prefetch_buffer;

    localparam int          ADDR_W   = 32;
    localparam int          DEPTH    = 4;
    localparam int          CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [31:0]       instr_pc;
    logic [CNT_W-1:0]  count;
    logic              respValid;

    int vectors     = 0;
    int miscompares = 0;
    int fixedLat    = 1;
    int popsSeen    = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] nextExpPc;

    ifetch_prefetch_buffer #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Memory never answers while reset is held.
    assign mem_rvalid = respValid & rst;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int pickLat();
        return (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 4));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic refill();
        exp_t e;
        while (expQ.size() < 8) begin
            e.pc   = nextExpPc;
            e.word = memWord(nextExpPc);
            expQ.push_back(e);
            nextExpPc = nextExpPc + 32'd4;
        end
    endtask

    task automatic restartModel(input logic [31:0] target);
        expQ.delete();
        nextExpPc = target & ~32'h3;
        refill();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        refill();
    endtask

    task automatic doReset(input int lat, input logic rdy);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        redirect    = 1'b0;
        fixedLat    = lat;
        instr_ready = rdy;
        repeat (2) @(posedge clk);
        #1;
        restartModel(RESET_PC);
        rst = 1'b1;
    endtask

    task automatic doRedirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        restartModel(target);
        tick();
        redirect = 1'b0;
    endtask

    // Memory responder: a request seen for L cycles is answered with a one-cycle rvalid.
    initial begin
        int age;
        int curLat;
        respValid = 1'b0;
        mem_rdata = '0;
        age       = 0;
        curLat    = 1;
        forever begin
            @(posedge clk);
            #1;
            if (respValid) begin
                respValid = 1'b0;
                age       = 0;
                curLat    = pickLat();
            end
            if (!rst) begin
                age    = 0;
                curLat = pickLat();
            end else if (!mem_req) begin
                age = 0;
            end else if (age >= curLat) begin
                respValid = 1'b1;
                mem_rdata = memWord(mem_addr);
            end else begin
                age++;
            end
        end
    end

    // Monitor: every accepted head must be the next entry of the expected stream.
    initial begin
        logic        prevReq;
        logic        prevRvalid;
        logic [31:0] prevAddr;
        exp_t        e;
        prevReq    = 1'b0;
        prevRvalid = 1'b0;
        prevAddr   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prevReq    = 1'b0;
                prevRvalid = 1'b0;
                continue;
            end
            if (prevReq && !prevRvalid) begin
                chk("req held", 32'(mem_req), 32'd1);
                chk("addr stable", mem_addr, prevAddr);
            end
            chk("valid vs count", 32'(instr_valid), 32'(count != '0));
            if (instr_valid && instr_ready && !redirect) begin
                popsSeen++;
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard: pop of pc %h with nothing expected", instr_pc);
                end else begin
                    e = expQ.pop_front();
                    chk("instr_pc", instr_pc, e.pc);
                    chk("instr", instr, e.word);
                end
            end
            prevReq    = mem_req;
            prevRvalid = mem_rvalid;
            prevAddr   = mem_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "timeout");
    end

    initial begin
        logic        found;
        logic [31:0] target;
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        fixedLat    = 1;
        nextExpPc   = RESET_PC;
        repeat (3) @(posedge clk);
        #1;
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_addr", mem_addr, RESET_PC);
        chk("rst instr_valid", 32'(instr_valid), 32'd0);
        chk("rst count", 32'(count), 32'd0);
        chk("rst instr", instr, 32'd0);
        chk("rst instr_pc", instr_pc, 32'd0);

        // T1: one-cycle memory, always ready
        instr_ready = 1'b1;
        restartModel(RESET_PC);
        rst = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk("T1 mem_req", 32'(mem_req), 32'd1);
            chk("T1 mem_addr", mem_addr, RESET_PC + 32'(4 * ((c - 1) / 2)));
        end
        repeat (10) tick();

        // T2: decode stalled until the buffer fills
        doReset(1, 1'b0);
        repeat (12) tick();
        chk("T2 count full", 32'(count), 32'd4);
        chk("T2 mem_req idle", 32'(mem_req), 32'd0);
        chk("T2 head pc", instr_pc, RESET_PC);
        chk("T2 head instr", instr, memWord(RESET_PC));
        repeat (3) tick();
        chk("T2 still idle", 32'(mem_req), 32'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("T2 reissue req", 32'(mem_req), 32'd1);
        chk("T2 reissue addr", mem_addr, 32'h10);
        chk("T2 count after pop", 32'(count), 32'd3);
        instr_ready = 1'b1;
        repeat (20) tick();

        // T3: redirect while a request is outstanding
        doReset(4, 1'b1);
        tick();
        chk("T3 wait req", 32'(mem_req), 32'd1);
        doRedirect(32'h100);
        chk("T3 discard req", 32'(mem_req), 32'd1);
        chk("T3 discard addr", mem_addr, RESET_PC);
        chk("T3 count flushed", 32'(count), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("T3 count zero", 32'(count), 32'd0);
            chk("T3 req pending", 32'(mem_req), 32'd1);
        end
        tick();
        chk("T3 dropped req", 32'(mem_req), 32'd0);
        chk("T3 dropped count", 32'(count), 32'd0);
        tick();
        chk("T3 new req", 32'(mem_req), 32'd1);
        chk("T3 new addr", mem_addr, 32'h100);
        repeat (30) tick();

        // T4: redirect coincident with rvalid and a pop
        doReset(1, 1'b0);
        repeat (4) tick();
        chk("T4 count before", 32'(count), 32'd1);
        instr_ready = 1'b1;
        doRedirect(32'h100);
        chk("T4 count", 32'(count), 32'd0);
        chk("T4 instr_valid", 32'(instr_valid), 32'd0);
        chk("T4 req idle", 32'(mem_req), 32'd0);
        tick();
        chk("T4 new req", 32'(mem_req), 32'd1);
        chk("T4 new addr", mem_addr, 32'h100);
        repeat (20) tick();

        // T5: unaligned target and address wrap
        doReset(1, 1'b1);
        doRedirect(32'h103);
        chk("T5 idle after redirect", 32'(mem_req), 32'd0);
        tick();
        chk("T5 req", 32'(mem_req), 32'd1);
        chk("T5 aligned addr", mem_addr, 32'h100);
        repeat (10) tick();
        doRedirect(32'hFFFF_FFFC);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (mem_req && mem_addr == 32'h0) found = 1'b1;
        end
        chk("T5 wrap to zero", 32'(found), 32'd1);
        repeat (10) tick();

        // T6: asynchronous reset in the middle of a request
        doReset(4, 1'b0);
        repeat (7) tick();
        chk("T6 count before", 32'(count), 32'd1);
        chk("T6 req before", 32'(mem_req), 32'd1);
        chk("T6 addr before", mem_addr, 32'h4);
        #2;
        rst = 1'b0;
        #1;
        chk("T6 async req", 32'(mem_req), 32'd0);
        chk("T6 async valid", 32'(instr_valid), 32'd0);
        chk("T6 async count", 32'(count), 32'd0);
        chk("T6 async addr", mem_addr, RESET_PC);
        @(posedge clk);
        #1;
        restartModel(RESET_PC);
        rst = 1'b1;
        tick();
        chk("T6 restart req", 32'(mem_req), 32'd1);
        chk("T6 restart addr", mem_addr, RESET_PC);
        instr_ready = 1'b1;
        repeat (20) tick();

        // Randomized stalls, latencies and redirects
        doReset(0, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 2))
                    0:       target = $urandom;
                    1:       target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                    default: target = 32'($urandom_range(0, 255));
                endcase
                doRedirect(target);
            end else begin
                tick();
            end
        end
        instr_ready = 1'b1;
        repeat (20) tick();
        chk("progress", 32'(popsSeen > 300), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
